// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, next-PC select codes and the
// pipeline-register bubble used by fetch and the pipeline registers.
package core_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_TRAP     = 2'b10,
    ST_MRET     = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_IADDER = 2'b01,
    PC_TRAP   = 2'b10,
    PC_MEPC   = 2'b11
  } pc_src_t;

  typedef struct packed {
    logic       rf_wr_en;
    logic [2:0] wb_mux_sel;
    logic       mem_wr;
    logic       csr_wr;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // A bubble is an instruction whose control fields are all zero.
  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID-stage read of the register an EX-stage
// load is about to write.
module hazard_detect
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd_addr,
  input  logic             load,
  output logic             hazard
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = rs1_used && (rs1_addr == rd_addr);
  assign rs2_hit = rs2_used && (rs2_addr == rd_addr);
  // x0 never carries a real dependency.
  assign hazard  = load && (rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/next-PC steering for load-use,
// branches, data-memory waits, traps and trap return.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [REG_W-1:0] rs1_addr_id_in,
  input  logic [REG_W-1:0] rs2_addr_id_in,
  input  logic             rs1_used_id_in,
  input  logic             rs2_used_id_in,
  input  logic [REG_W-1:0] rd_addr_ex_in,
  input  logic             load_ex_in,
  input  logic             branch_taken_in,
  input  logic             dmem_req_in,
  input  logic             dmem_ack_in,
  input  logic             trap_req_in,
  input  logic             mret_in,
  output logic             stall_pc_out,
  output logic             stall_ifid_out,
  output logic             stall_idex_out,
  output logic             flush_ifid_out,
  output logic             flush_idex_out,
  output logic [1:0]       pc_src_out,
  output logic             bus_err_out,
  output logic [1:0]       state_out
);

  localparam logic [4:0] WAIT_LAST = 5'(WAIT_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [4:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;

  hazard_detect u_hazard_detect (
    .rs1_addr (rs1_addr_id_in),
    .rs2_addr (rs2_addr_id_in),
    .rs1_used (rs1_used_id_in),
    .rs2_used (rs2_used_id_in),
    .rd_addr  (rd_addr_ex_in),
    .load     (load_ex_in),
    .hazard   (load_use)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;
    stall_pc_out   = 1'b0;
    stall_ifid_out = 1'b0;
    stall_idex_out = 1'b0;
    flush_ifid_out = 1'b0;
    flush_idex_out = 1'b0;
    pc_src_out     = PC_PLUS4;
    bus_err_out    = 1'b0;
    if (!reset_in) begin
      // Reset inserts bubbles so nothing half-fetched survives.
      state_d        = ST_RUN;
      flush_ifid_out = 1'b1;
      flush_idex_out = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (trap_req_in) begin
            state_d        = ST_TRAP;
            flush_ifid_out = 1'b1;
            flush_idex_out = 1'b1;
            pc_src_out     = PC_TRAP;
          end else if (mret_in) begin
            state_d        = ST_MRET;
            flush_ifid_out = 1'b1;
            flush_idex_out = 1'b1;
            pc_src_out     = PC_MEPC;
          end else if (dmem_req_in && !dmem_ack_in) begin
            state_d        = ST_MEM_WAIT;
            stall_pc_out   = 1'b1;
            stall_ifid_out = 1'b1;
            stall_idex_out = 1'b1;
          end else if (branch_taken_in) begin
            flush_ifid_out = 1'b1;
            flush_idex_out = 1'b1;
            pc_src_out     = PC_IADDER;
          end else if (load_use) begin
            stall_pc_out   = 1'b1;
            stall_ifid_out = 1'b1;
            flush_idex_out = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          stall_pc_out   = 1'b1;
          stall_ifid_out = 1'b1;
          stall_idex_out = 1'b1;
          // Timeout wins over a late ack; trap requests wait for RUN.
          if (wait_cnt_q == WAIT_LAST) begin
            state_d     = ST_TRAP;
            bus_err_out = 1'b1;
          end else if (dmem_ack_in) begin
            state_d = ST_RUN;
          end else begin
            wait_cnt_d = wait_cnt_q + 5'd1;
          end
        end
        default: begin
          state_d        = ST_RUN;
          flush_ifid_out = 1'b1;
          flush_idex_out = 1'b1;
        end
      endcase
    end
  end

  assign state_out = state_q;

endmodule
